imm_gen_stage: RTL and testbench

- Registered, flow-controlled immediate generator for the pipecpu decode/execute boundary.
- Accepts instruction, IMM op, PC and tag over a valid/ready handshake, and emits the extended immediate plus PC-relative target one cycle later.
- Generalised in XLEN (32/64) and adds a CSR zimm format, an illegal-op flag, flush, and a 2-entry skid buffer so `in_ready` never combinationally depends on `out_ready`.

---
 rtl/imm_gen_stage_pkg.sv | 37 +++
 rtl/imm_gen_stage_format.sv | 69 ++++++
 rtl/imm_gen_stage.sv | 135 +++++++++++++
 tb/tb_imm_gen_stage.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_stage_pkg.sv
// imm_gen_stage_pkg
//   Shared constants and types for the immediate generator stage.
//   - IMM_CTRL_* : immediate format select encodings (IMM_OP_W_DEF bits,
//                  all mutually distinct). The base RV32/64 codes keep their
//                  established values; ZIMM and the RVC codes are new.
//   - stage_state_t : occupancy of the output/skid register pair, encoded
//                     as {out_valid, sk_valid}.
//   Optional feature macro: IMMGEN_RVC_EN (the RVC codes are always defined
//   here but are only decoded when the macro is set).
package imm_gen_stage_pkg;

    localparam int IMM_OP_W_DEF = 6;

    typedef logic [IMM_OP_W_DEF-1:0] imm_op_t;

    localparam imm_op_t IMM_CTRL_ITYPE_SHAMT = 6'h01;
    localparam imm_op_t IMM_CTRL_ITYPE       = 6'h02;
    localparam imm_op_t IMM_CTRL_STYPE       = 6'h03;
    localparam imm_op_t IMM_CTRL_BTYPE       = 6'h04;
    localparam imm_op_t IMM_CTRL_UTYPE       = 6'h05;
    localparam imm_op_t IMM_CTRL_JTYPE       = 6'h06;
    localparam imm_op_t IMM_CTRL_ZIMM        = 6'h07;
    localparam imm_op_t IMM_CTRL_CI          = 6'h08;
    localparam imm_op_t IMM_CTRL_CSS         = 6'h09;
    localparam imm_op_t IMM_CTRL_CIW         = 6'h0A;
    localparam imm_op_t IMM_CTRL_CL          = 6'h0B;
    localparam imm_op_t IMM_CTRL_CB          = 6'h0C;
    localparam imm_op_t IMM_CTRL_CJ          = 6'h0D;

    // Encoded as {out_valid, sk_valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL1 = 2'b10,
        ST_FULL2 = 2'b11
    } stage_state_t;

endpackage

// File: rtl/imm_gen_stage_format.sv
// imm_format
//   Purely combinational immediate extraction: instruction + format select
//   in, XLEN-wide extended immediate and an illegal-select flag out.
//   Ports:
//     instr [31:0]        raw instruction
//     op    [IMM_OP_W-1:0] IMM_CTRL_* format select
//     imm   [XLEN-1:0]    extended immediate (0 on an undefined select)
//     err                 1 when op is not a decoded encoding
//   Optional feature macro: IMMGEN_RVC_EN adds the compressed formats
//   (CI/CSS/CIW/CL/CB/CJ) decoded from instr[15:0].
module imm_format
    import imm_gen_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int IMM_OP_W = 6
) (
    input  logic [31:0]         instr,
    input  logic [IMM_OP_W-1:0] op,
    output logic [XLEN-1:0]     imm,
    output logic                err
);

    // Opcode bits never feed an immediate in the base formats.
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^instr[6:0];

    // Size casts of $signed() values sign-extend; plain casts zero-extend.
    always_comb begin
        imm = '0;
        err = 1'b0;
        case (op)
            IMM_OP_W'(IMM_CTRL_ITYPE_SHAMT):
                imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
            IMM_OP_W'(IMM_CTRL_ITYPE):
                imm = XLEN'($signed(instr[31:20]));
            IMM_OP_W'(IMM_CTRL_STYPE):
                imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            IMM_OP_W'(IMM_CTRL_BTYPE):
                imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            IMM_OP_W'(IMM_CTRL_UTYPE):
                imm = XLEN'($signed({instr[31:12], 12'b0}));
            IMM_OP_W'(IMM_CTRL_JTYPE):
                imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            IMM_OP_W'(IMM_CTRL_ZIMM):
                imm = XLEN'(instr[19:15]);
`ifdef IMMGEN_RVC_EN
            IMM_OP_W'(IMM_CTRL_CI):
                imm = XLEN'($signed({instr[12], instr[6:2]}));
            IMM_OP_W'(IMM_CTRL_CSS):
                imm = XLEN'({instr[8:7], instr[12:9], 2'b0});
            IMM_OP_W'(IMM_CTRL_CIW):
                imm = XLEN'({instr[10:7], instr[12:11], instr[5], instr[6], 2'b0});
            IMM_OP_W'(IMM_CTRL_CL):
                imm = XLEN'({instr[5], instr[12:10], instr[6], 2'b0});
            IMM_OP_W'(IMM_CTRL_CB):
                imm = XLEN'($signed({instr[12], instr[6:5], instr[2], instr[11:10],
                                     instr[4:3], 1'b0}));
            IMM_OP_W'(IMM_CTRL_CJ):
                imm = XLEN'($signed({instr[12], instr[8], instr[10:9], instr[6], instr[7],
                                     instr[2], instr[11], instr[5:3], 1'b0}));
`endif
            default: begin
                imm = '0;
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage
//   Registered, flow-controlled immediate generator at the decode/execute
//   boundary. An output register plus one skid register make in_ready a
//   pure flop output, independent of out_ready.
//   Handshake: a beat moves on a port only in a cycle where valid and ready
//   are both high at the rising edge; valid never waits on ready, and an
//   offered beat is held stable by its source until it transfers.
//   Ports:
//     clk, rst (sync, active-high), flush (sync, drops all held entries)
//     in_valid/in_ready, in_instr[31:0], in_imm_op, in_pc[XLEN-1:0], in_tag
//     out_valid/out_ready, out_imm, out_target (= pc + imm, wraps),
//     out_tag, out_imm_err (select was undefined)
//   XLEN must be 32 or 64.
//   Optional feature macro: IMMGEN_RVC_EN (compressed formats, see imm_format).
module imm_gen_stage
    import imm_gen_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int IMM_OP_W = 6,
    parameter int TAG_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [IMM_OP_W-1:0] in_imm_op,
    input  logic [XLEN-1:0]     in_pc,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_imm,
    output logic [XLEN-1:0]     out_target,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_imm_err
);

    // Input-side formation; the result loads into whichever slot is free.
    logic [XLEN-1:0] fmt_imm;
    logic [XLEN-1:0] fmt_target;
    logic            fmt_err;

    imm_format #(.XLEN(XLEN), .IMM_OP_W(IMM_OP_W)) u_format (
        .instr (in_instr),
        .op    (in_imm_op),
        .imm   (fmt_imm),
        .err   (fmt_err)
    );

    assign fmt_target = in_pc + fmt_imm;

    logic                sk_valid;
    logic [XLEN-1:0]     sk_imm;
    logic [XLEN-1:0]     sk_target;
    logic [TAG_W-1:0]    sk_tag;
    logic                sk_imm_err;

    stage_state_t state;
    logic         accept;
    logic         take;

    assign state  = stage_state_t'({out_valid, sk_valid});
    assign accept = in_valid & in_ready;
    assign take   = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            sk_valid    <= 1'b0;
            in_ready    <= 1'b1;
            out_imm     <= '0;
            out_target  <= '0;
            out_tag     <= '0;
            out_imm_err <= 1'b0;
            sk_imm      <= '0;
            sk_target   <= '0;
            sk_tag      <= '0;
            sk_imm_err  <= 1'b0;
        end else if (flush) begin
            // Data registers keep their contents; only occupancy is dropped.
            out_valid <= 1'b0;
            sk_valid  <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        out_valid   <= 1'b1;
                        out_imm     <= fmt_imm;
                        out_target  <= fmt_target;
                        out_tag     <= in_tag;
                        out_imm_err <= fmt_err;
                    end
                end
                ST_FULL1: begin
                    if (accept && take) begin
                        out_imm     <= fmt_imm;
                        out_target  <= fmt_target;
                        out_tag     <= in_tag;
                        out_imm_err <= fmt_err;
                    end else if (accept) begin
                        // Output is stuck: park the new beat and close the input.
                        sk_valid   <= 1'b1;
                        in_ready   <= 1'b0;
                        sk_imm     <= fmt_imm;
                        sk_target  <= fmt_target;
                        sk_tag     <= in_tag;
                        sk_imm_err <= fmt_err;
                    end else if (take) begin
                        out_valid <= 1'b0;
                    end
                end
                ST_FULL2: begin
                    // in_ready is low here, so no accept can coincide.
                    if (take) begin
                        sk_valid    <= 1'b0;
                        in_ready    <= 1'b1;
                        out_imm     <= sk_imm;
                        out_target  <= sk_target;
                        out_tag     <= sk_tag;
                        out_imm_err <= sk_imm_err;
                    end
                end
                default: begin
                    // Skid-without-output cannot be reached; recover to empty.
                    out_valid <= 1'b0;
                    sk_valid  <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage
//   Bench for imm_gen_stage: an XLEN=32 instance driven through the
//   handshake with a queue scoreboard, plus an XLEN=64 instance for the
//   wide-format cases. Optional feature macro: IMMGEN_RVC_EN.
module tb_imm_gen_stage;
    import imm_gen_stage_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid, in_ready, out_valid, out_ready, out_imm_err;
    logic [31:0] in_instr, in_pc, out_imm, out_target;
    logic [5:0]  in_imm_op;
    logic [3:0]  in_tag, out_tag;

    logic        in_valid64, in_ready64, out_valid64, out_ready64, out_imm_err64;
    logic [31:0] in_instr64;
    logic [5:0]  in_imm_op64;
    logic [63:0] in_pc64, out_imm64, out_target64;
    logic [3:0]  in_tag64, out_tag64;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .IMM_OP_W(6), .TAG_W(4)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_imm_op(in_imm_op), .in_pc(in_pc), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_target(out_target), .out_tag(out_tag), .out_imm_err(out_imm_err)
    );

    imm_gen_stage #(.XLEN(64), .IMM_OP_W(6), .TAG_W(4)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64),
        .in_imm_op(in_imm_op64), .in_pc(in_pc64), .in_tag(in_tag64),
        .out_valid(out_valid64), .out_ready(out_ready64), .out_imm(out_imm64),
        .out_target(out_target64), .out_tag(out_tag64), .out_imm_err(out_imm_err64)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_imm_q[$];
    logic [31:0] exp_tgt_q[$];
    logic [3:0]  exp_tag_q[$];
    logic [0:0]  exp_err_q[$];
    logic [31:0] e_imm, e_tgt;
    logic [3:0]  e_tag;
    logic [0:0]  e_err;

    // Reference formats for XLEN=32, returned as {err, imm}.
    function automatic logic [32:0] ref_imm(input logic [31:0] i, input logic [5:0] op);
        case (op)
            IMM_CTRL_ITYPE_SHAMT: return {1'b0, 27'b0, i[24:20]};
            IMM_CTRL_ITYPE:       return {1'b0, {20{i[31]}}, i[31:20]};
            IMM_CTRL_STYPE:       return {1'b0, {20{i[31]}}, i[31:25], i[11:7]};
            IMM_CTRL_BTYPE:       return {1'b0, {19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_CTRL_UTYPE:       return {1'b0, i[31:12], 12'b0};
            IMM_CTRL_JTYPE:       return {1'b0, {11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            IMM_CTRL_ZIMM:        return {1'b0, 27'b0, i[19:15]};
`ifdef IMMGEN_RVC_EN
            IMM_CTRL_CI:  return {1'b0, {26{i[12]}}, i[12], i[6:2]};
            IMM_CTRL_CSS: return {1'b0, 24'b0, i[8:7], i[12:9], 2'b0};
            IMM_CTRL_CIW: return {1'b0, 22'b0, i[10:7], i[12:11], i[5], i[6], 2'b0};
            IMM_CTRL_CL:  return {1'b0, 25'b0, i[5], i[12:10], i[6], 2'b0};
            IMM_CTRL_CB:  return {1'b0, {23{i[12]}}, i[12], i[6:5], i[2], i[11:10], i[4:3], 1'b0};
            IMM_CTRL_CJ:  return {1'b0, {20{i[12]}}, i[12], i[8], i[10:9], i[6], i[7], i[2],
                                  i[11], i[5:3], 1'b0};
`endif
            default:              return {1'b1, 32'b0};
        endcase
    endfunction

    // ---------------- driver ----------------
    // Drives one cycle of inputs at the falling edge and records the expected
    // result when the beat will be accepted at the next rising edge.
    task automatic drive(input logic v, input logic [31:0] instr, input logic [5:0] op,
                         input logic [31:0] pc, input logic [3:0] tag,
                         input logic ordy, input logic fl);
        logic [32:0] r;
        @(negedge clk);
        in_valid  = v;
        in_instr  = instr;
        in_imm_op = op;
        in_pc     = pc;
        in_tag    = tag;
        out_ready = ordy;
        flush     = fl;
        #1;
        if (v && in_ready && !fl) begin
            r = ref_imm(instr, op);
            exp_imm_q.push_back(r[31:0]);
            exp_tgt_q.push_back(pc + r[31:0]);
            exp_tag_q.push_back(tag);
            exp_err_q.push_back(r[32]);
        end
    endtask

    task automatic clear_sb();
        exp_imm_q.delete();
        exp_tgt_q.delete();
        exp_tag_q.delete();
        exp_err_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        n_checks++; if ({out_imm, out_target, out_tag, out_imm_err} !== 69'd0)
            $display("FAIL reset_data: got imm %h tgt %h tag %h err %b want all 0",
                     out_imm, out_target, out_tag, out_imm_err);
        else n_pass++;
        n_checks++; if (in_ready64 !== 1'b1 || out_valid64 !== 1'b0)
            $display("FAIL reset64: got in_ready %b out_valid %b want 1 0", in_ready64, out_valid64);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_itype();
        clear_sb();
        drive(1'b1, 32'hFFF00093, IMM_CTRL_ITYPE, 32'h100, 4'd1, 1'b1, 1'b0);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL itype_latency: got out_valid %b want 0", out_valid); else n_pass++;
        drive(1'b0, 32'h0, 6'h0, 32'h0, 4'd0, 1'b1, 1'b0);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL itype_valid: got %b want 1", out_valid); else n_pass++;
        n_checks++; if (out_imm !== 32'hFFFFFFFF) $display("FAIL itype_imm: got %h want ffffffff", out_imm); else n_pass++;
        n_checks++; if (out_target !== 32'h000000FF) $display("FAIL itype_target: got %h want 000000ff", out_target); else n_pass++;
        n_checks++; if (out_imm_err !== 1'b0 || out_tag !== 4'd1)
            $display("FAIL itype_err_tag: got err %b tag %h want 0 1", out_imm_err, out_tag);
        else n_pass++;
    endtask

    task automatic test_btype_and_undef();
        clear_sb();
        drive(1'b1, 32'hFE000EE3, IMM_CTRL_BTYPE, 32'h100, 4'd2, 1'b1, 1'b0);
        drive(1'b1, 32'h12345678, 6'h3F, 32'h200, 4'd3, 1'b1, 1'b0);
        n_checks++; if (out_imm !== 32'hFFFFFFFC || out_target !== 32'h000000FC || out_valid !== 1'b1)
            $display("FAIL btype: got v %b imm %h tgt %h want 1 fffffffc 000000fc", out_valid, out_imm, out_target);
        else n_pass++;
        drive(1'b1, 32'hFFFFFFFF, IMM_CTRL_CJ, 32'h300, 4'd4, 1'b1, 1'b0);
        n_checks++; if (out_imm !== 32'h0 || out_imm_err !== 1'b1 || out_target !== 32'h200)
            $display("FAIL undef_op: got imm %h err %b tgt %h want 0 1 200", out_imm, out_imm_err, out_target);
        else n_pass++;
        drive(1'b0, 32'h0, 6'h0, 32'h0, 4'd0, 1'b1, 1'b0);
`ifdef IMMGEN_RVC_EN
        n_checks++; if (out_imm !== 32'hFFFFFFFE || out_imm_err !== 1'b0)
            $display("FAIL rvc_cj: got imm %h err %b want fffffffe 0", out_imm, out_imm_err);
        else n_pass++;
`else
        n_checks++; if (out_imm !== 32'h0 || out_imm_err !== 1'b1)
            $display("FAIL rvc_absent: got imm %h err %b want 0 1", out_imm, out_imm_err);
        else n_pass++;
`endif
        drive(1'b0, 32'h0, 6'h0, 32'h0, 4'd0, 1'b1, 1'b0);
    endtask

    task automatic test_xlen64();
        @(negedge clk);
        in_valid64 = 1'b1; in_instr64 = 32'h800000B7; in_imm_op64 = IMM_CTRL_UTYPE;
        in_pc64 = 64'h1000; in_tag64 = 4'd7; out_ready64 = 1'b1;
        @(negedge clk);
        in_instr64 = 32'h03F09093; in_imm_op64 = IMM_CTRL_ITYPE_SHAMT; in_pc64 = 64'h0; in_tag64 = 4'd8;
        #1;
        n_checks++; if (out_valid64 !== 1'b1 || out_imm64 !== 64'hFFFFFFFF80000000 || out_target64 !== 64'hFFFFFFFF80001000)
            $display("FAIL x64_utype: got v %b imm %h tgt %h want 1 ffffffff80000000 ffffffff80001000",
                     out_valid64, out_imm64, out_target64);
        else n_pass++;
        @(negedge clk);
        in_valid64 = 1'b0;
        #1;
        n_checks++; if (out_imm64 !== 64'd63 || out_target64 !== 64'd63 || out_tag64 !== 4'd8)
            $display("FAIL x64_shamt: got imm %h tgt %h tag %h want 3f 3f 8", out_imm64, out_target64, out_tag64);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic pending;
        clear_sb();
        drive(1'b1, 32'h00500093, IMM_CTRL_ITYPE, 32'h40, 4'd0, 1'b0, 1'b0);
        drive(1'b1, 32'h00A12223, IMM_CTRL_STYPE, 32'h44, 4'd1, 1'b0, 1'b0);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_second_accept: got in_ready %b want 1", in_ready); else n_pass++;
        drive(1'b1, 32'h0000F0EF, IMM_CTRL_JTYPE, 32'h48, 4'd2, 1'b0, 1'b0);
        n_checks++; if (in_ready !== 1'b0 || exp_tag_q.size() != 2)
            $display("FAIL b2b_third_held: got in_ready %b queued %0d want 0 2", in_ready, exp_tag_q.size());
        else n_pass++;
        pending = 1'b1;
        for (int c = 0; c < 12; c++) begin
            drive(pending, 32'h0000F0EF, IMM_CTRL_JTYPE, 32'h48, 4'd2, 1'b1, 1'b0);
            if (pending && in_ready) pending = 1'b0;
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_tag_q.size() == 0) $display("FAIL b2b_extra: got tag %h want no output", out_tag);
                else begin
                    e_imm = exp_imm_q.pop_front(); e_tgt = exp_tgt_q.pop_front();
                    e_tag = exp_tag_q.pop_front(); e_err = exp_err_q.pop_front();
                    if ({out_imm, out_target, out_tag, out_imm_err} !== {e_imm, e_tgt, e_tag, e_err})
                        $display("FAIL b2b_out: got imm %h tgt %h tag %h err %b want imm %h tgt %h tag %h err %b",
                                 out_imm, out_target, out_tag, out_imm_err, e_imm, e_tgt, e_tag, e_err);
                    else n_pass++;
                end
            end
            if (!pending && exp_tag_q.size() == 0 && c > 4) break;
        end
        n_checks++; if (pending || exp_tag_q.size() != 0)
            $display("FAIL b2b_drain: got pending %b left %0d want 0 0", pending, exp_tag_q.size());
        else n_pass++;
    endtask

    task automatic test_flush();
        clear_sb();
        drive(1'b1, 32'h00100093, IMM_CTRL_ITYPE, 32'h0, 4'd5, 1'b0, 1'b0);
        drive(1'b1, 32'h00200093, IMM_CTRL_ITYPE, 32'h0, 4'd6, 1'b0, 1'b0);
        drive(1'b1, 32'h00300093, IMM_CTRL_ITYPE, 32'h0, 4'd7, 1'b0, 1'b1);
        clear_sb();
        drive(1'b0, 32'h0, 6'h0, 32'h0, 4'd0, 1'b1, 1'b0);
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_state: got out_valid %b in_ready %b want 0 1", out_valid, in_ready);
        else n_pass++;
        drive(1'b0, 32'h0, 6'h0, 32'h0, 4'd0, 1'b1, 1'b0);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_no_ghost: got out_valid %b tag %h want 0", out_valid, out_tag); else n_pass++;
    endtask

    task automatic test_reset_mid_stall();
        clear_sb();
        drive(1'b1, 32'h80000037, IMM_CTRL_UTYPE, 32'h10, 4'd8, 1'b0, 1'b0);
        drive(1'b1, 32'h80000037, IMM_CTRL_UTYPE, 32'h10, 4'd9, 1'b0, 1'b0);
        drive(1'b1, 32'h80000037, IMM_CTRL_UTYPE, 32'h10, 4'd10, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL rst_stall_state: got out_valid %b in_ready %b want 0 1", out_valid, in_ready);
        else n_pass++;
        n_checks++; if ({out_imm, out_target, out_tag, out_imm_err} !== 69'd0)
            $display("FAIL rst_stall_data: got imm %h tgt %h tag %h err %b want all 0",
                     out_imm, out_target, out_tag, out_imm_err);
        else n_pass++;
        rst = 1'b0;
        in_valid = 1'b0;
        clear_sb();
    endtask

    task automatic test_stream();
        imm_op_t ops[9];
        ops = '{IMM_CTRL_ITYPE_SHAMT, IMM_CTRL_ITYPE, IMM_CTRL_STYPE, IMM_CTRL_BTYPE,
                IMM_CTRL_UTYPE, IMM_CTRL_JTYPE, IMM_CTRL_ZIMM, 6'h3F, IMM_CTRL_CI};
        clear_sb();
        for (int c = 0; c < 300; c++) begin
            drive(1'($urandom_range(0, 1)), $urandom, ops[$urandom_range(0, 8)], $urandom,
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0), 1'b0);
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_tag_q.size() == 0) $display("FAIL stream_extra: got tag %h want no output", out_tag);
                else begin
                    e_imm = exp_imm_q.pop_front(); e_tgt = exp_tgt_q.pop_front();
                    e_tag = exp_tag_q.pop_front(); e_err = exp_err_q.pop_front();
                    if ({out_imm, out_target, out_tag, out_imm_err} !== {e_imm, e_tgt, e_tag, e_err})
                        $display("FAIL stream_out: got imm %h tgt %h tag %h err %b want imm %h tgt %h tag %h err %b",
                                 out_imm, out_target, out_tag, out_imm_err, e_imm, e_tgt, e_tag, e_err);
                    else n_pass++;
                end
            end
        end
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 32'h0, 6'h0, 32'h0, 4'd0, 1'b1, 1'b0);
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_tag_q.size() == 0) $display("FAIL stream_extra: got tag %h want no output", out_tag);
                else begin
                    e_imm = exp_imm_q.pop_front(); e_tgt = exp_tgt_q.pop_front();
                    e_tag = exp_tag_q.pop_front(); e_err = exp_err_q.pop_front();
                    if ({out_imm, out_target, out_tag, out_imm_err} !== {e_imm, e_tgt, e_tag, e_err})
                        $display("FAIL stream_out: got imm %h tgt %h tag %h err %b want imm %h tgt %h tag %h err %b",
                                 out_imm, out_target, out_tag, out_imm_err, e_imm, e_tgt, e_tag, e_err);
                    else n_pass++;
                end
            end
        end
        n_checks++; if (exp_tag_q.size() != 0 || out_valid !== 1'b0)
            $display("FAIL stream_drain: got left %0d out_valid %b want 0 0", exp_tag_q.size(), out_valid);
        else n_pass++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_instr = '0; in_imm_op = '0; in_pc = '0; in_tag = '0; out_ready = 1'b0;
        in_valid64 = 1'b0; in_instr64 = '0; in_imm_op64 = '0; in_pc64 = '0; in_tag64 = '0; out_ready64 = 1'b0;
        test_reset();
        test_itype();
        test_btype_and_undef();
        test_xlen64();
        test_back_to_back();
        test_flush();
        test_reset_mid_stall();
        test_stream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
